// File: rtl/cycle_pkg.sv
// rtl/cycle_pkg.sv - shared color codes, FSM states and color sequence helpers
package cycle_pkg;

  localparam logic [2:0] COLOR_RED     = 3'd0;
  localparam logic [2:0] COLOR_YELLOW  = 3'd1;
  localparam logic [2:0] COLOR_GREEN   = 3'd2;
  localparam logic [2:0] COLOR_CYAN    = 3'd3;
  localparam logic [2:0] COLOR_BLUE    = 3'd4;
  localparam logic [2:0] COLOR_MAGENTA = 3'd5;
  localparam logic [2:0] COLOR_INVALID = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_e;

  // Successor of a color in the legal six-color ring; INVALID has none.
  function automatic logic [2:0] next_color(input logic [2:0] color);
    case (color)
      COLOR_RED:     next_color = COLOR_YELLOW;
      COLOR_YELLOW:  next_color = COLOR_GREEN;
      COLOR_GREEN:   next_color = COLOR_CYAN;
      COLOR_CYAN:    next_color = COLOR_BLUE;
      COLOR_BLUE:    next_color = COLOR_MAGENTA;
      COLOR_MAGENTA: next_color = COLOR_RED;
      default:       next_color = COLOR_INVALID;
    endcase
  endfunction

  // Map LED drive levels to a color code; all-off and all-on are not colors.
  function automatic logic [2:0] decode_rgb(input logic r, input logic g, input logic b);
    case ({r, g, b})
      3'b100:  decode_rgb = COLOR_RED;
      3'b110:  decode_rgb = COLOR_YELLOW;
      3'b010:  decode_rgb = COLOR_GREEN;
      3'b011:  decode_rgb = COLOR_CYAN;
      3'b001:  decode_rgb = COLOR_BLUE;
      3'b101:  decode_rgb = COLOR_MAGENTA;
      default: decode_rgb = COLOR_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer for one asynchronous level
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cycle_monitor.sv
// rtl/cycle_monitor.sv - RGB color cycle sequence and dwell-time monitor
module cycle_monitor
  import cycle_pkg::*;
#(
  parameter int COLOR_INTERVAL = 2000000,
  parameter int TOL            = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 red,
  input  logic                                 green,
  input  logic                                 blue,
  output logic [2:0]                           color_code,
  output logic [$clog2(COLOR_INTERVAL+TOL):0]  dwell_count,
  output logic                                 locked,
  output logic                                 seq_error,
  output logic                                 timing_error,
  output logic [7:0]                           cycles_seen
);

  localparam int DW = $clog2(COLOR_INTERVAL + TOL) + 1;
  localparam logic [DW-1:0] DWELL_ONE   = DW'(1);
  localparam logic [DW-1:0] DWELL_SAT   = '1;
  localparam logic [DW-1:0] DWELL_MIN   = DW'(COLOR_INTERVAL - TOL);
  localparam logic [DW-1:0] DWELL_MAX   = DW'(COLOR_INTERVAL + TOL);
  localparam logic [DW-1:0] DWELL_LIMIT = DW'(COLOR_INTERVAL + TOL + 1);

  logic          red_s, green_s, blue_s;
  logic [2:0]    sync_color;
  logic          transition;
  logic          legal;
  logic          in_window;

  logic [2:0]    color_q, color_d;
  logic [DW-1:0] dwell_q, dwell_d;
  state_e        state_q;
  logic          locked_q;
  logic          seq_err_q;
  logic          tim_err_q;
  logic [7:0]    cycles_q;

  bit_sync u_sync_red   (.clk(clk), .rst(rst), .d_i(red),   .q_o(red_s));
  bit_sync u_sync_green (.clk(clk), .rst(rst), .d_i(green), .q_o(green_s));
  bit_sync u_sync_blue  (.clk(clk), .rst(rst), .d_i(blue),  .q_o(blue_s));

  assign sync_color = decode_rgb(red_s, green_s, blue_s);
  assign transition = (sync_color != color_q);
  assign legal      = (sync_color == next_color(color_q));
  // dwell_q here is the finished dwell of the color being left.
  assign in_window  = (dwell_q >= DWELL_MIN) && (dwell_q <= DWELL_MAX);

  // Next color and dwell: restart at 1 on a change, otherwise count up and stick at all-ones.
  always_comb begin
    color_d = color_q;
    dwell_d = dwell_q;
    if (transition) begin
      color_d = sync_color;
      dwell_d = DWELL_ONE;
    end else if (dwell_q != DWELL_SAT) begin
      dwell_d = dwell_q + DWELL_ONE;
    end
  end

  // Current color and how long it has been held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q <= COLOR_INVALID;
      dwell_q <= '0;
    end else begin
      color_q <= color_d;
      dwell_q <= dwell_d;
    end
  end

  // Lock-tracking FSM with its registered status and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      locked_q  <= 1'b0;
      seq_err_q <= 1'b0;
      tim_err_q <= 1'b0;
      cycles_q  <= 8'd0;
    end else begin
      seq_err_q <= 1'b0;
      tim_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (transition && (sync_color != COLOR_INVALID)) begin
            state_q <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          // First dwell after (re)acquisition is never timed.
          if (transition) begin
            if (sync_color == COLOR_INVALID) begin
              state_q <= ST_IDLE;
            end else if (legal) begin
              state_q  <= ST_TRACK;
              locked_q <= 1'b1;
            end else begin
              seq_err_q <= 1'b1;
            end
          end
        end
        ST_TRACK: begin
          if (transition) begin
            if (legal) begin
              tim_err_q <= !in_window;
              if (color_q == COLOR_MAGENTA) begin
                cycles_q <= cycles_q + 8'd1;
              end
            end else begin
              // A sequence error masks any dwell error on the same change.
              seq_err_q <= 1'b1;
              locked_q  <= 1'b0;
              state_q   <= (sync_color == COLOR_INVALID) ? ST_IDLE : ST_ACQUIRE;
            end
          end else if (dwell_q == DWELL_LIMIT) begin
            // Stuck color: flag once and drop lock so it cannot repeat.
            tim_err_q <= 1'b1;
            locked_q  <= 1'b0;
            state_q   <= ST_ACQUIRE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign color_code   = color_q;
  assign dwell_count  = dwell_q;
  assign locked       = locked_q;
  assign seq_error    = seq_err_q;
  assign timing_error = tim_err_q;
  assign cycles_seen  = cycles_q;

endmodule

// File: tb/tb_cycle_monitor.sv
// tb/tb_cycle_monitor.sv - directed self-checking bench for cycle_monitor
module tb_cycle_monitor;

  localparam logic [2:0] RGB_OFF     = 3'b000;
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;

  logic       clk;
  logic       rst;
  logic       red, green, blue;
  logic [2:0] color_code;
  logic [4:0] dwell_count;
  logic       locked;
  logic       seq_error;
  logic       timing_error;
  logic [7:0] cycles_seen;

  int n_checks = 0;
  int n_fail   = 0;
  int se_cnt   = 0;
  int te_cnt   = 0;

  cycle_monitor #(.COLOR_INTERVAL(8), .TOL(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .color_code   (color_code),
    .dwell_count  (dwell_count),
    .locked       (locked),
    .seq_error    (seq_error),
    .timing_error (timing_error),
    .cycles_seen  (cycles_seen)
  );

  always #5 clk = ~clk;

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (seq_error)    se_cnt++;
      if (timing_error) te_cnt++;
    end
  endtask

  task automatic hold(input logic [2:0] rgb, input int n);
    {red, green, blue} = rgb;
    run(n);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (color_code !== 3'd7) begin n_fail++; $display("FAIL reset_color: got %0d want 7", color_code); end
    n_checks++; if (dwell_count !== 5'd0) begin n_fail++; $display("FAIL reset_dwell: got %0d want 0", dwell_count); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if ({seq_error, timing_error} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b want 00", {seq_error, timing_error}); end
    n_checks++; if (cycles_seen !== 8'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", cycles_seen); end
    rst = 1'b0;
    se_cnt = 0; te_cnt = 0;
    run(4);
    n_checks++; if (color_code !== 3'd7 || locked !== 1'b0 || se_cnt != 0) begin n_fail++; $display("FAIL idle_dark: color %0d locked %b se %0d want 7 0 0", color_code, locked, se_cnt); end
  endtask

  task automatic test_ideal_cycle;
    se_cnt = 0; te_cnt = 0;
    hold(RGB_RED, 8);
    n_checks++; if (color_code !== 3'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL ideal_acquire: color %0d locked %b want 0 0", color_code, locked); end
    hold(RGB_YELLOW, 8);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ideal_lock: got %b want 1", locked); end
    hold(RGB_GREEN, 8); hold(RGB_CYAN, 8); hold(RGB_BLUE, 8); hold(RGB_MAGENTA, 8);
    n_checks++; if (cycles_seen !== 8'd0) begin n_fail++; $display("FAIL ideal_cycles_pre: got %0d want 0", cycles_seen); end
    hold(RGB_RED, 8);
    n_checks++; if (cycles_seen !== 8'd1) begin n_fail++; $display("FAIL ideal_cycles_post: got %0d want 1", cycles_seen); end
    hold(RGB_YELLOW, 8); hold(RGB_GREEN, 8); hold(RGB_CYAN, 8); hold(RGB_BLUE, 8); hold(RGB_MAGENTA, 8);
    n_checks++; if (se_cnt != 0 || te_cnt != 0) begin n_fail++; $display("FAIL ideal_no_errs: se %0d te %0d want 0 0", se_cnt, te_cnt); end
    n_checks++; if (color_code !== 3'd5 || dwell_count !== 5'd6) begin n_fail++; $display("FAIL ideal_dwell: color %0d dwell %0d want 5 6", color_code, dwell_count); end
    n_checks++; if (locked !== 1'b1 || cycles_seen !== 8'd1) begin n_fail++; $display("FAIL ideal_end: locked %b cycles %0d want 1 1", locked, cycles_seen); end
  endtask

  task automatic test_dwell_window;
    se_cnt = 0; te_cnt = 0;
    hold(RGB_RED, 8); hold(RGB_YELLOW, 8); hold(RGB_GREEN, 10);
    n_checks++; if (te_cnt != 0 || cycles_seen !== 8'd2) begin n_fail++; $display("FAIL window_pre: te %0d cycles %0d want 0 2", te_cnt, cycles_seen); end
    hold(RGB_CYAN, 8);
    n_checks++; if (te_cnt != 1) begin n_fail++; $display("FAIL window_long: te %0d want 1", te_cnt); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL window_long_locked: got %b want 1", locked); end
    hold(RGB_BLUE, 7); hold(RGB_MAGENTA, 8);
    n_checks++; if (te_cnt != 1 || se_cnt != 0 || locked !== 1'b1) begin n_fail++; $display("FAIL window_short_ok: te %0d se %0d locked %b want 1 0 1", te_cnt, se_cnt, locked); end
  endtask

  task automatic test_seq_jump;
    hold(RGB_RED, 8); hold(RGB_YELLOW, 8); hold(RGB_GREEN, 8); hold(RGB_CYAN, 8); hold(RGB_BLUE, 8);
    se_cnt = 0; te_cnt = 0;
    hold(RGB_RED, 3);
    n_checks++; if (se_cnt != 1 || te_cnt != 0) begin n_fail++; $display("FAIL jump_pulse: se %0d te %0d want 1 0", se_cnt, te_cnt); end
    n_checks++; if (locked !== 1'b0 || color_code !== 3'd0) begin n_fail++; $display("FAIL jump_state: locked %b color %0d want 0 0", locked, color_code); end
    n_checks++; if (cycles_seen !== 8'd3) begin n_fail++; $display("FAIL jump_cycles: got %0d want 3", cycles_seen); end
    hold(RGB_YELLOW, 8);
    n_checks++; if (locked !== 1'b1 || te_cnt != 0 || se_cnt != 1) begin n_fail++; $display("FAIL jump_relock: locked %b te %0d se %0d want 1 0 1", locked, te_cnt, se_cnt); end
  endtask

  task automatic test_freeze_timeout;
    hold(RGB_GREEN, 8);
    se_cnt = 0; te_cnt = 0;
    {red, green, blue} = RGB_CYAN;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seq_error) se_cnt++;
      if (timing_error) begin
        te_cnt++;
        n_checks++; if (dwell_count !== 5'd11) begin n_fail++; $display("FAIL freeze_at: dwell %0d want 11", dwell_count); end
      end
    end
    n_checks++; if (te_cnt != 1 || se_cnt != 0) begin n_fail++; $display("FAIL freeze_pulse: te %0d se %0d want 1 0", te_cnt, se_cnt); end
    n_checks++; if (locked !== 1'b0 || color_code !== 3'd3) begin n_fail++; $display("FAIL freeze_state: locked %b color %0d want 0 3", locked, color_code); end
    n_checks++; if (dwell_count !== 5'd31) begin n_fail++; $display("FAIL freeze_sat: dwell %0d want 31", dwell_count); end
  endtask

  task automatic test_invalid;
    hold(RGB_BLUE, 8);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL inv_prelock: got %b want 1", locked); end
    se_cnt = 0; te_cnt = 0;
    hold(RGB_OFF, 8);
    n_checks++; if (se_cnt != 1 || te_cnt != 0) begin n_fail++; $display("FAIL inv_pulse: se %0d te %0d want 1 0", se_cnt, te_cnt); end
    n_checks++; if (color_code !== 3'd7 || locked !== 1'b0) begin n_fail++; $display("FAIL inv_state: color %0d locked %b want 7 0", color_code, locked); end
    hold(RGB_RED, 8);
    n_checks++; if (locked !== 1'b0 || color_code !== 3'd0) begin n_fail++; $display("FAIL inv_acq: locked %b color %0d want 0 0", locked, color_code); end
    hold(RGB_YELLOW, 8);
    n_checks++; if (locked !== 1'b1 || se_cnt != 1 || te_cnt != 0) begin n_fail++; $display("FAIL inv_relock: locked %b se %0d te %0d want 1 1 0", locked, se_cnt, te_cnt); end
  endtask

  task automatic test_reset_mid_dwell;
    hold(RGB_GREEN, 8); hold(RGB_CYAN, 8); hold(RGB_BLUE, 8); hold(RGB_MAGENTA, 6);
    n_checks++; if (color_code !== 3'd5 || dwell_count !== 5'd4 || cycles_seen !== 8'd3) begin n_fail++; $display("FAIL mid_pre: color %0d dwell %0d cycles %0d want 5 4 3", color_code, dwell_count, cycles_seen); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (color_code !== 3'd7 || dwell_count !== 5'd0) begin n_fail++; $display("FAIL mid_rst_cd: color %0d dwell %0d want 7 0", color_code, dwell_count); end
    n_checks++; if (locked !== 1'b0 || seq_error !== 1'b0 || timing_error !== 1'b0 || cycles_seen !== 8'd0) begin n_fail++; $display("FAIL mid_rst_status: locked %b se %b te %b cycles %0d want 0 0 0 0", locked, seq_error, timing_error, cycles_seen); end
    @(negedge clk);
    rst = 1'b0;
    se_cnt = 0; te_cnt = 0;
    run(4);
    n_checks++; if (color_code !== 3'd5 || locked !== 1'b0) begin n_fail++; $display("FAIL mid_reacq: color %0d locked %b want 5 0", color_code, locked); end
    hold(RGB_RED, 3);
    n_checks++; if (locked !== 1'b1 || te_cnt != 0 || se_cnt != 0) begin n_fail++; $display("FAIL mid_unchecked: locked %b te %0d se %0d want 1 0 0", locked, te_cnt, se_cnt); end
    n_checks++; if (cycles_seen !== 8'd0 || color_code !== 3'd0) begin n_fail++; $display("FAIL mid_cycles: cycles %0d color %0d want 0 0", cycles_seen, color_code); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    {red, green, blue} = RGB_OFF;
    test_reset;
    test_ideal_cycle;
    test_dwell_window;
    test_seq_jump;
    test_freeze_timeout;
    test_invalid;
    test_reset_mid_dwell;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
